video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Parametrised, multi-mode HDMI/DVI test-pattern source in the pixel clock domain, feeding the `rgb` input of the `dvi` encoder.
- Generalises the fixed XOR pattern with these additions:
  - six selectable patterns;
  - frame-animated scrolling;
  - a debounced push-button mode cycle plus a direct mode load;
  - tear-free mode switching at frame start;
  - blanking of pixels outside the visible area.

Parameters:
- COORD_W, 11: width of the cx/cy/geometry inputs.
- COLOR_W, 8: bits per colour channel; `rgb` is 3*COLOR_W bits.
- BAR_SHIFT, 7: colour-bar width is 2^BAR_SHIFT pixels.
- CHECK_SHIFT, 5: checkerboard square size is 2^CHECK_SHIFT pixels.
- GRAD_SHIFT, 2: gradient coordinate right-shift.
- DEBOUNCE_CYCLES, 742500: cycles the button must stay stable to be accepted (10 ms at 74.25 MHz).
- FRAME_CNT_W, 16: frame counter width.

Ports:
- clk_pixel, in, 1: pixel clock; the only clock.
- rst, in, 1: asynchronous, active-high reset.
- cx, in, COORD_W: current x position from `dvi`.
- cy, in, COORD_W: current y position from `dvi`.
- screen_start_x, in, COORD_W: first visible column.
- screen_start_y, in, COORD_W: first visible row.
- screen_width, in, COORD_W: visible width.
- screen_height, in, COORD_W: visible height.
- btn, in, 1: raw, asynchronous mode-cycle button (active-high).
- mode_load, in, 1: strobe; loads `mode_in` as the pending mode.
- mode_in, in, 3: mode value for `mode_load`.
- scroll_en, in, 1: enables XOR scroll animation.
- solid_rgb, in, 3*COLOR_W: colour used in SOLID mode.
- rgb, out, 3*COLOR_W: pixel colour, ordered {R,G,B}.
- active, out, 1: pixel on `rgb` is in the visible area.
- mode, out, 3: committed (displayed) mode.
- mode_pending, out, 3: mode to be committed at the next frame start.
- frame_count, out, FRAME_CNT_W: completed-frame counter.

Behaviour:
- Reset: `rgb`, `active`, `mode`, `mode_pending` and `frame_count` all go to 0. The synchroniser, debounced level and debounce counter all go to 0 (button released).
- Pipeline: 2 cycles of latency from cx/cy to rgb/active.
  - Stage 1 registers:
    - px = cx - screen_start_x and py = cy - screen_start_y, both COORD_W bits, modulo.
    - vis = (cx >= screen_start_x) && (cy >= screen_start_y).
    - sof = (cx == 0 && cy == 0).
  - Stage 2 registers `rgb` and `active` = vis.
  - When vis = 0, `rgb` = 0.
- Frame start: when stage-1 sof = 1, in the same cycle:
  - frame_count increments (wraps at 2^FRAME_CNT_W - 1 to 0);
  - mode <= mode_pending.
  - The stage-2 pixel of that cycle already uses the new mode.
- Mode control:
  - btn passes through a 2-FF synchroniser.
  - The debounced level changes only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. The counter clears whenever the values are equal.
  - A rising edge of the debounced level sets mode_pending to mode_pending + 1, wrapping 5 -> 0.
  - mode_load = 1 sets mode_pending to mode_in; mode_in values 6 and 7 load 0.
  - mode_load takes priority over a same-cycle button edge; that edge is discarded.
- Pattern definitions: FULL = all ones on a COLOR_W channel.
  - 0 XOR: c = (px ^ py)[COLOR_W-1:0] + (scroll_en ? frame_count[COLOR_W-1:0] : 0), modulo 2^COLOR_W; R = G = B = c.
  - 1 BARS: b = px[BAR_SHIFT+2:BAR_SHIFT]; {R,G,B} channel on/off bits = ~b.
    - Order: white, yellow, magenta, red, cyan, green, blue, black.
    - Repeats every 8 bars.
  - 2 CHECKER: px[CHECK_SHIFT] ^ py[CHECK_SHIFT] gives white; otherwise black.
  - 3 GRADIENT: R = (px >> GRAD_SHIFT)[COLOR_W-1:0]; G = (py >> GRAD_SHIFT)[COLOR_W-1:0]; B = 0.
  - 4 SOLID: rgb = solid_rgb.
  - 5 BORDER, with priority in this order:
    - white if px == 0, py == 0, px == screen_width-1 or py == screen_height-1;
    - else red {FULL,0,0} if px == screen_width>>1 or py == screen_height>>1;
    - else black.
  - Unreachable modes 6/7 output black.
- Asynchronous rst mid-frame clears everything immediately. After release:
  - the pattern restarts in XOR mode;
  - the first sof increments frame_count to 1.

Test Plan:
- Reset, then run a 1280x720 frame with start 0/0 in XOR mode, scroll_en=0. Drive cx=3, cy=5 -> two cycles later rgb = 0x060606 and active = 1.
- scroll_en=1 with frame_count=0x0010 at cx=3, cy=5 -> rgb = 0x161616. frame_count wraps 0xFFFF -> 0 at the next sof.
- mode_load=1, mode_in=1 mid-frame:
  - mode_pending=1 immediately; mode stays 0 until sof.
  - In the next frame, px=128 -> rgb = 0xFFFF00 and px=896 -> 0x000000.
- Button behaviour:
  - Pulse btn high for DEBOUNCE_CYCLES-1 cycles -> mode_pending unchanged.
  - Hold btn for DEBOUNCE_CYCLES+4 cycles -> mode_pending increments once.
  - Repeat from mode_pending=5 -> mode_pending becomes 0.
  - Debounced rising edge in the same cycle as mode_load with mode_in=7 -> mode_pending = 0, edge ignored.
- BORDER mode, screen_start_x=260, screen_width=1280, screen_height=720:
  - cx=260 -> white;
  - cx=900 (px=640), cy=100 -> 0xFF0000;
  - cx=100 -> active=0, rgb=0.
- Assert rst for 1 cycle in mid-frame in mode 3 -> rgb, active, mode and frame_count are 0 asynchronously, and the XOR pattern resumes with latency 2.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Multi-mode test-pattern source for the DVI encoder: two-stage pixel pipeline,
// debounced mode-cycle button, direct mode load and tear-free mode commit at frame start.
module video_pattern_gen #(
  parameter int unsigned COORD_W         = 11,
  parameter int unsigned COLOR_W         = 8,
  parameter int unsigned BAR_SHIFT       = 7,
  parameter int unsigned CHECK_SHIFT     = 5,
  parameter int unsigned GRAD_SHIFT      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 742500,
  parameter int unsigned FRAME_CNT_W     = 16
) (
  input  logic                     clk_pixel,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       cx,
  input  logic [COORD_W-1:0]       cy,
  input  logic [COORD_W-1:0]       screen_start_x,
  input  logic [COORD_W-1:0]       screen_start_y,
  input  logic [COORD_W-1:0]       screen_width,
  input  logic [COORD_W-1:0]       screen_height,
  input  logic                     btn,
  input  logic                     mode_load,
  input  logic [2:0]               mode_in,
  input  logic                     scroll_en,
  input  logic [3*COLOR_W-1:0]     solid_rgb,
  output logic [3*COLOR_W-1:0]     rgb,
  output logic                     active,
  output logic [2:0]               mode,
  output logic [2:0]               mode_pending,
  output logic [FRAME_CNT_W-1:0]   frame_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0] ModeXor      = 3'd0;
  localparam logic [2:0] ModeBars     = 3'd1;
  localparam logic [2:0] ModeChecker  = 3'd2;
  localparam logic [2:0] ModeGradient = 3'd3;
  localparam logic [2:0] ModeSolid    = 3'd4;
  localparam logic [2:0] ModeBorder   = 3'd5;

  // Stage 1
  logic [COORD_W-1:0] r_px, r_py;
  logic               r_vis, r_sof;

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      r_px  <= '0;
      r_py  <= '0;
      r_vis <= 1'b0;
      r_sof <= 1'b0;
    end else begin
      r_px  <= cx - screen_start_x;
      r_py  <= cy - screen_start_y;
      r_vis <= (cx >= screen_start_x) && (cy >= screen_start_y);
      r_sof <= (cx == '0) && (cy == '0);
    end
  end

  // Button synchroniser and debouncer
  logic [1:0]     r_sync;
  logic           r_btn_db;
  logic [DbW-1:0] r_db_cnt;
  logic           w_db_flip, w_db_rise;

  assign w_db_flip = (r_sync[1] != r_btn_db) && (r_db_cnt == DbW'(DEBOUNCE_CYCLES - 1));
  assign w_db_rise = w_db_flip && r_sync[1];

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], btn};
      if (r_sync[1] == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_db_cnt <= '0;
        r_btn_db <= r_sync[1];
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  // Mode control
  logic [2:0]             r_mode, r_mode_pending, w_pend_d;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  always_comb begin
    w_pend_d = r_mode_pending;
    if (mode_load) begin
      w_pend_d = (mode_in > ModeBorder) ? ModeXor : mode_in;
    end else if (w_db_rise) begin
      w_pend_d = (r_mode_pending == ModeBorder) ? ModeXor : r_mode_pending + 3'd1;
    end
  end

  // Stage 2 pattern generation; the frame-start pixel already sees the new mode
  logic [2:0]           w_mode_eff;
  logic [COLOR_W-1:0]   w_scroll, w_xor_c, w_gx, w_gy;
  logic [2:0]           w_bar_on;
  logic                 w_brd_edge, w_brd_mid;
  logic [3*COLOR_W-1:0] w_pix;

  assign w_mode_eff = r_sof ? r_mode_pending : r_mode;
  assign w_scroll   = scroll_en ? r_frame_count[COLOR_W-1:0] : '0;
  assign w_xor_c    = COLOR_W'(r_px ^ r_py) + w_scroll;
  assign w_bar_on   = ~r_px[BAR_SHIFT+2:BAR_SHIFT];
  assign w_gx       = COLOR_W'(r_px >> GRAD_SHIFT);
  assign w_gy       = COLOR_W'(r_py >> GRAD_SHIFT);
  assign w_brd_edge = (r_px == '0) || (r_py == '0) ||
                      (r_px == screen_width - COORD_W'(1)) ||
                      (r_py == screen_height - COORD_W'(1));
  assign w_brd_mid  = (r_px == (screen_width >> 1)) || (r_py == (screen_height >> 1));

  always_comb begin
    w_pix = '0;
    case (w_mode_eff)
      ModeXor:      w_pix = {3{w_xor_c}};
      ModeBars:     w_pix = {{COLOR_W{w_bar_on[2]}}, {COLOR_W{w_bar_on[1]}},
                             {COLOR_W{w_bar_on[0]}}};
      ModeChecker:  w_pix = {(3*COLOR_W){r_px[CHECK_SHIFT] ^ r_py[CHECK_SHIFT]}};
      ModeGradient: w_pix = {w_gx, w_gy, {COLOR_W{1'b0}}};
      ModeSolid:    w_pix = solid_rgb;
      ModeBorder: begin
        if (w_brd_edge) begin
          w_pix = '1;
        end else if (w_brd_mid) begin
          w_pix = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
        end
      end
      default:      w_pix = '0;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      rgb            <= '0;
      active         <= 1'b0;
      r_mode         <= ModeXor;
      r_mode_pending <= ModeXor;
      r_frame_count  <= '0;
    end else begin
      rgb            <= r_vis ? w_pix : '0;
      active         <= r_vis;
      r_mode_pending <= w_pend_d;
      if (r_sof) begin
        r_mode        <= r_mode_pending;
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign mode         = r_mode;
  assign mode_pending = r_mode_pending;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed scenarios plus randomized pixels, buttons and
// mode loads, checked every cycle against a behavioural pixel/mode model.
module tb_video_pattern_gen;

  localparam int CW  = 11;
  localparam int DB  = 16;
  localparam int FW  = 10;
  localparam int FCM = 1 << FW;

  logic          clk_pixel = 1'b0;
  logic          rst;
  logic [CW-1:0] cx, cy, ss_x, ss_y, sw, sh;
  logic          btn, mode_load, scroll_en;
  logic [2:0]    mode_in;
  logic [23:0]   solid_rgb;
  logic [23:0]   rgb;
  logic          active;
  logic [2:0]    mode, mode_pending;
  logic [FW-1:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int          s1_px, s1_py;
  bit          s1_vis, s1_sof;
  int          m_mode, m_pend, m_fc;
  bit          sy0, sy1, db;
  int          run;
  int unsigned e_rgb;
  bit          e_act;

  video_pattern_gen #(
    .COORD_W        (CW),
    .COLOR_W        (8),
    .BAR_SHIFT      (7),
    .CHECK_SHIFT    (5),
    .GRAD_SHIFT     (2),
    .DEBOUNCE_CYCLES(DB),
    .FRAME_CNT_W    (FW)
  ) u_dut (
    .clk_pixel     (clk_pixel),
    .rst           (rst),
    .cx            (cx),
    .cy            (cy),
    .screen_start_x(ss_x),
    .screen_start_y(ss_y),
    .screen_width  (sw),
    .screen_height (sh),
    .btn           (btn),
    .mode_load     (mode_load),
    .mode_in       (mode_in),
    .scroll_en     (scroll_en),
    .solid_rgb     (solid_rgb),
    .rgb           (rgb),
    .active        (active),
    .mode          (mode),
    .mode_pending  (mode_pending),
    .frame_count   (frame_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned ref_pixel(int px, int py, int md, int fc, bit scr,
                                            int unsigned solid, int w, int h);
    int unsigned c;
    int unsigned bar_rgb [8];
    bar_rgb = '{32'hFFFFFF, 32'hFFFF00, 32'hFF00FF, 32'hFF0000,
                32'h00FFFF, 32'h00FF00, 32'h0000FF, 32'h000000};
    case (md)
      0: begin
        c = int'(((px ^ py) + (scr ? fc : 0)) % 256);
        return (c << 16) | (c << 8) | c;
      end
      1: return bar_rgb[(px / 128) % 8];
      2: return ((((px / 32) + (py / 32)) % 2) == 1) ? 32'hFFFFFF : 32'h0;
      3: return (((px / 4) % 256) << 16) | (((py / 4) % 256) << 8);
      4: return solid;
      5: begin
        if (px == 0 || py == 0 || px == ((w - 1) & 2047) || py == ((h - 1) & 2047))
          return 32'hFFFFFF;
        if (px == w / 2 || py == h / 2) return 32'hFF0000;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    s1_px = 0; s1_py = 0; s1_vis = 0; s1_sof = 0;
    m_mode = 0; m_pend = 0; m_fc = 0;
    sy0 = 0; sy1 = 0; db = 0; run = 0;
  endtask

  // True when the coming clock edge will accept a debounced press
  function automatic bit model_rise_next();
    return (sy1 != db) && (run + 1 == DB) && sy1;
  endfunction

  task automatic model_edge();
    int md;
    bit rise;
    md    = s1_sof ? m_pend : m_mode;
    e_act = s1_vis;
    e_rgb = s1_vis ? ref_pixel(s1_px, s1_py, md, m_fc, scroll_en, solid_rgb, sw, sh) : 0;
    if (s1_sof) begin
      m_mode = m_pend;
      m_fc   = (m_fc + 1) % FCM;
    end
    rise = 0;
    if (sy1 != db) begin
      run++;
      if (run == DB) begin
        db   = sy1;
        rise = db;
        run  = 0;
      end
    end else begin
      run = 0;
    end
    if (mode_load) m_pend = (mode_in > 5) ? 0 : int'(mode_in);
    else if (rise) m_pend = (m_pend + 1) % 6;
    s1_px  = (int'(cx) - int'(ss_x)) & 2047;
    s1_py  = (int'(cy) - int'(ss_y)) & 2047;
    s1_vis = (cx >= ss_x) && (cy >= ss_y);
    s1_sof = (cx == 0) && (cy == 0);
    sy1 = sy0;
    sy0 = btn;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_eq("rgb", rgb, e_rgb);
    check_eq("active", active, e_act);
    check_eq("mode", mode, m_mode);
    check_eq("mode_pending", mode_pending, m_pend);
    check_eq("frame_count", frame_count, m_fc);
  endtask

  task automatic drive(input int x, input int y);
    cx = 11'(x);
    cy = 11'(y);
    step();
  endtask

  task automatic drive_rand();
    drive(int'($urandom_range(1, 1700)), int'($urandom_range(1, 900)));
  endtask

  task automatic load_mode(input int m);
    mode_load = 1'b1;
    mode_in   = 3'(m);
    drive_rand();
    mode_load = 1'b0;
  endtask

  task automatic hold_btn(input int hi_cycles);
    btn = 1'b1;
    repeat (hi_cycles) drive_rand();
    btn = 1'b0;
    repeat (40) drive_rand();
  endtask

  initial begin
    bit seen;
    int btn_left;
    rst = 1'b1;
    cx = '0; cy = '0; ss_x = '0; ss_y = '0; sw = 11'd1280; sh = 11'd720;
    btn = 1'b0; mode_load = 1'b0; mode_in = '0; scroll_en = 1'b0; solid_rgb = 24'h123456;
    model_reset();
    repeat (2) @(negedge clk_pixel);
    check_eq("rst_rgb", rgb, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_pending", mode_pending, 0);
    check_eq("rst_fcnt", frame_count, 0);
    rst = 1'b0;

    // XOR pixel latency
    drive(3, 5);
    drive(10, 10);
    check_eq("xor_3_5", rgb, 32'h060606);
    check_eq("xor_active", active, 1);

    // Scroll with frame_count = 16, then counter wrap
    repeat (16) drive(0, 0);
    scroll_en = 1'b1;
    drive(3, 5);
    drive(7, 9);
    check_eq("xor_scroll", rgb, 32'h161616);
    scroll_en = 1'b0;
    repeat (FCM - 1 - 16) drive(0, 0);
    drive(4, 4);
    check_eq("fc_max", frame_count, FCM - 1);
    drive(0, 0);
    drive(1, 1);
    check_eq("fc_wrap", frame_count, 0);

    // Mid-frame mode load commits only at frame start
    mode_load = 1'b1; mode_in = 3'd1;
    drive(100, 100);
    mode_load = 1'b0;
    check_eq("ld_pending", mode_pending, 1);
    check_eq("ld_mode_held", mode, 0);
    drive(200, 100);
    check_eq("ld_mode_held2", mode, 0);
    drive(0, 0);
    drive(128, 10);
    drive(896, 10);
    check_eq("bar_yellow", rgb, 32'hFFFF00);
    drive(5, 10);
    check_eq("bar_black", rgb, 32'h000000);
    check_eq("bar_active", active, 1);

    // Debounced button
    hold_btn(DB - 1);
    check_eq("btn_short", mode_pending, 1);
    hold_btn(DB + 4);
    check_eq("btn_long", mode_pending, 2);
    load_mode(5);
    hold_btn(DB + 4);
    check_eq("btn_wrap", mode_pending, 0);
    load_mode(3);
    seen = 0;
    btn  = 1'b1;
    repeat (DB + 8) begin
      if (model_rise_next()) begin
        seen = 1;
        mode_load = 1'b1;
        mode_in   = 3'd7;
      end
      drive_rand();
      mode_load = 1'b0;
    end
    btn = 1'b0;
    repeat (40) drive_rand();
    check_eq("rise_seen", seen, 1);
    check_eq("ld_vs_btn", mode_pending, 0);

    // Border mode with offset visible area
    ss_x = 11'd260;
    load_mode(5);
    drive(0, 0);
    drive(260, 50);
    drive(900, 100);
    check_eq("brd_white", rgb, 32'hFFFFFF);
    drive(100, 100);
    check_eq("brd_mid", rgb, 32'hFF0000);
    drive(300, 300);
    check_eq("brd_off_rgb", rgb, 0);
    check_eq("brd_off_act", active, 0);

    // Asynchronous reset mid-frame in gradient mode
    ss_x = '0;
    load_mode(3);
    drive(0, 0);
    repeat (5) drive_rand();
    rst = 1'b1;
    #1;
    check_eq("arst_rgb", rgb, 0);
    check_eq("arst_active", active, 0);
    check_eq("arst_mode", mode, 0);
    check_eq("arst_fcnt", frame_count, 0);
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst = 1'b0;
    model_reset();
    drive(3, 5);
    drive(8, 8);
    check_eq("post_rst_xor", rgb, 32'h060606);
    drive(0, 0);
    drive(9, 9);
    check_eq("post_rst_fc", frame_count, 1);

    // Randomized traffic
    btn_left = 0;
    for (int i = 0; i < 2500; i++) begin
      int sel;
      if (i % 250 == 0) begin
        ss_x      = 11'($urandom_range(0, 300));
        ss_y      = 11'($urandom_range(0, 100));
        sw        = ($urandom_range(0, 1) == 0) ? 11'd1280 : 11'd640;
        sh        = ($urandom_range(0, 1) == 0) ? 11'd720 : 11'd480;
        solid_rgb = 24'($urandom);
        scroll_en = 1'($urandom_range(0, 1));
      end
      if (btn_left == 0) begin
        btn      = ~btn;
        btn_left = int'($urandom_range(1, 40));
      end
      btn_left--;
      mode_load = ($urandom_range(0, 29) == 0);
      mode_in   = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      drive(0, 0);
      else if (sel == 1) drive(int'(ss_x) + int'(sw) / 2, int'($urandom_range(0, 900)));
      else if (sel == 2) drive(int'(ss_x) + int'(sw) - 1, int'($urandom_range(0, 900)));
      else if (sel == 3) drive(int'($urandom_range(0, 1700)), int'(ss_y) + int'(sh) / 2);
      else               drive(int'($urandom_range(0, 1700)), int'($urandom_range(0, 900)));
    end
    mode_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
